// File: rtl/armv8_pkg.sv
// Shared ARMv8 integer register-file constants and types.
package armv8_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam logic [AW-1:0] REG_XZR = 5'd31;

  typedef logic [XLEN-1:0] xreg_t;
  typedef logic [AW-1:0]   xaddr_t;
endpackage

// File: rtl/regfile_write_decode_decoder.sv
// 5-to-32 one-hot decoder with enable; used for write strobes and issue set strobes.
module decoder5to32 (
  output logic [31:0] F,
  input  logic        En,
  input  logic [4:0]  A
);
  assign F = En ? (32'b1 << A) : 32'b0;
endmodule

// File: rtl/regfile_write_decode.sv
// ARMv8 X0..X30 register file with XZR at index 31, one-hot write decode and busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining WRITE_BYPASS_EN.
module regfile_write_decode
  import armv8_pkg::*;
#(
  parameter int N    = XLEN,
  parameter int NREG = armv8_pkg::NREG,
  parameter int AW   = armv8_pkg::AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [N-1:0]  rd_data_a,
  output logic [N-1:0]  rd_data_b,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  output logic          busy_a,
  output logic          busy_b
);
  logic [31:0]    wr_sel;
  logic [31:0]    iss_sel;
  logic [N-1:0]   regs [NREG-1];
  logic [NREG-2:0] busy;
  logic           unused_xzr_sel;

  decoder5to32 u_dec_wr  (.F(wr_sel),  .En(wr_en),  .A(wr_addr));
  decoder5to32 u_dec_iss (.F(iss_sel), .En(iss_en), .A(iss_addr));

  // XZR lines of both decoders deliberately go nowhere.
  assign unused_xzr_sel = wr_sel[31] ^ iss_sel[31];

  genvar gi;
  generate
    for (gi = 0; gi < NREG - 1; gi++) begin : g_reg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          regs[gi] <= '0;
          busy[gi] <= 1'b0;
        end else begin
          if (wr_sel[gi])
            regs[gi] <= wr_data;
          // Issue set wins over write-back clear on the same register.
          if (iss_sel[gi])
            busy[gi] <= 1'b1;
          else if (wr_sel[gi])
            busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  logic [N-1:0] stored_a, stored_b;
  logic         sb_a, sb_b;

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    sb_a     = 1'b0;
    sb_b     = 1'b0;
    for (int i = 0; i < NREG - 1; i++) begin
      if (rd_addr_a == AW'(i)) begin
        stored_a = regs[i];
        sb_a     = busy[i];
      end
      if (rd_addr_b == AW'(i)) begin
        stored_b = regs[i];
        sb_b     = busy[i];
      end
    end
  end

`ifdef WRITE_BYPASS_EN
  logic hit_a, hit_b;
  assign hit_a = wr_en && (wr_addr != REG_XZR) && (rd_addr_a == wr_addr);
  assign hit_b = wr_en && (wr_addr != REG_XZR) && (rd_addr_b == wr_addr);

  // A forwarded register is only busy again if this cycle's issue re-marks it.
  assign rd_data_a = hit_a ? wr_data : stored_a;
  assign rd_data_b = hit_b ? wr_data : stored_b;
  assign busy_a    = hit_a ? (iss_en && (iss_addr == rd_addr_a)) : sb_a;
  assign busy_b    = hit_b ? (iss_en && (iss_addr == rd_addr_b)) : sb_b;
`else
  assign rd_data_a = stored_a;
  assign rd_data_b = stored_b;
  assign busy_a    = sb_a;
  assign busy_b    = sb_b;
`endif

endmodule

// File: tb/tb_regfile_write_decode.sv
// Directed self-checking bench for regfile_write_decode (table vectors plus multi-cycle sequences).
module tb_regfile_write_decode;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [63:0] rd_data_a, rd_data_b;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_write_decode dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_a(busy_a), .busy_b(busy_b)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [63:0] ea;
    logic [63:0] eb;
    logic        eba;
    logic        ebb;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [63:0] wd, logic ie, logic [4:0] ia,
                              logic [4:0] ra, logic [4:0] rb, logic [63:0] ea, logic [63:0] eb,
                              logic eba, logic ebb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One write/issue cycle, then enables dropped and registered state checked.
  task automatic step(vec_t v, int idx);
    @(negedge clk);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    iss_en = v.ie; iss_addr = v.ia;
    rd_addr_a = v.ra; rd_addr_b = v.rb;
    @(posedge clk);
    #1;
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    chk($sformatf("vec%0d rd_data_a", idx), rd_data_a, v.ea);
    chk($sformatf("vec%0d rd_data_b", idx), rd_data_b, v.eb);
    chk($sformatf("vec%0d busy_a", idx), {63'b0, busy_a}, {63'b0, v.eba});
    chk($sformatf("vec%0d busy_b", idx), {63'b0, busy_b}, {63'b0, v.ebb});
  endtask

  task automatic cyc(logic we, logic [4:0] wa, logic [63:0] wd, logic ie, logic [4:0] ia);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; iss_en = ie; iss_addr = ia;
    @(posedge clk);
    #1;
    wr_en = 1'b0; iss_en = 1'b0;
  endtask

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0123_4567;

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    rd_addr_a = '0; rd_addr_b = '0;

    vecs[0]  = mk(1, 5'd5,  DB,            0, 5'd0,  5'd5,  5'd6,  DB,      64'd0,   0, 0);
    vecs[1]  = mk(1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 5'd0, 5'd31, 5'd5, 64'd0, DB, 0, 0);
    vecs[2]  = mk(0, 5'd0,  64'd0,         1, 5'd31, 5'd31, 5'd31, 64'd0,   64'd0,   0, 0);
    vecs[3]  = mk(0, 5'd0,  64'd0,         1, 5'd7,  5'd7,  5'd5,  64'd0,   DB,      1, 0);
    vecs[4]  = mk(1, 5'd7,  64'h77,        1, 5'd7,  5'd7,  5'd6,  64'h77,  64'd0,   1, 0);
    vecs[5]  = mk(1, 5'd7,  64'h88,        0, 5'd0,  5'd7,  5'd5,  64'h88,  DB,      0, 0);
    vecs[6]  = mk(1, 5'd0,  64'h1,         0, 5'd0,  5'd0,  5'd7,  64'h1,   64'h88,  0, 0);
    vecs[7]  = mk(1, 5'd30, 64'h30,        1, 5'd2,  5'd30, 5'd2,  64'h30,  64'd0,   0, 1);
    vecs[8]  = mk(1, 5'd2,  64'h22,        0, 5'd0,  5'd2,  5'd30, 64'h22,  64'h30,  0, 0);
    vecs[9]  = mk(1, 5'd3,  64'h55,        0, 5'd0,  5'd3,  5'd1,  64'h55,  64'd0,   0, 0);
    vecs[10] = mk(0, 5'd0,  64'd0,         0, 5'd0,  5'd5,  5'd0,  DB,      64'h1,   0, 0);

    // Reset state: every address reads zero and not busy.
    repeat (2) @(posedge clk);
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a);
      #1;
      chk($sformatf("reset rd_data_a[%0d]", a), rd_data_a, 64'd0);
      chk($sformatf("reset busy_a[%0d]", a), {63'b0, busy_a}, 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) step(vecs[i], i);

    // Same-cycle write to X3 while reading it; X3 currently holds 0x55.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234;
    rd_addr_a = 5'd3;
    #1;
`ifdef WRITE_BYPASS_EN
    chk("bypass pre-edge rd_data_a", rd_data_a, 64'h1234);
`else
    chk("bypass pre-edge rd_data_a", rd_data_a, 64'h55);
`endif
    chk("bypass pre-edge busy_a", {63'b0, busy_a}, 64'd0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    chk("bypass post-edge rd_data_a", rd_data_a, 64'h1234);

    // Fill X0..X30 with their index, mark X9 busy, then reset between edges.
    for (int r = 0; r < 31; r++) cyc(1'b1, 5'(r), 64'(r), 1'b0, 5'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
    rd_addr_a = 5'd9; rd_addr_b = 5'd30;
    #1;
    chk("prefill rd_data_a X9", rd_data_a, 64'd9);
    chk("prefill rd_data_b X30", rd_data_b, 64'd30);
    chk("prefill busy_a X9", {63'b0, busy_a}, 64'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset rd_data_a X9", rd_data_a, 64'd0);
    chk("async reset busy_a X9", {63'b0, busy_a}, 64'd0);
    chk("async reset rd_data_b X30", rd_data_b, 64'd0);
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a);
      #0.1;
      chk($sformatf("mid reset rd_data_a[%0d]", a), rd_data_a, 64'd0);
      chk($sformatf("mid reset busy_a[%0d]", a), {63'b0, busy_a}, 64'd0);
    end
    // A write presented while reset is held is lost.
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hABCD;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd_addr_a = 5'd12;
    #1;
    chk("write during reset lost", rd_data_a, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $finish;
  end
endmodule
